// File: rtl/ras_restorable_pkg.sv
// Shared types and constants for the fetch-predictor return address stack.
// Holds the default geometry, the overflow policy encodings and the
// per-cycle operation decode used by the stack core.
package ras_restorable_pkg;

    // Default geometry. The module re-derives the widths from its own
    // parameters, so these are the values used when nothing is overridden.
    localparam int RAS_ENTRIES      = 8;
    localparam int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
    localparam int RAS_TARGET_WIDTH = 31;
    localparam int RAS_COUNT_WIDTH  = $clog2(RAS_ENTRIES + 1);

    // Behaviour of a push that arrives while the stack is full.
    localparam int RAS_OVERFLOW_WRAP = 0;  // overwrite the oldest entry
    localparam int RAS_OVERFLOW_DROP = 1;  // discard the push

    // One operation is performed per cycle. A restore from the update path
    // dominates; a simultaneous call+return replaces the top entry in place.
    typedef enum logic [2:0] {
        RAS_OP_IDLE    = 3'd0,
        RAS_OP_PUSH    = 3'd1,
        RAS_OP_POP     = 3'd2,
        RAS_OP_REPLACE = 3'd3,
        RAS_OP_RESTORE = 3'd4
    } ras_op_e;

    // Collapse the three request strobes into the single operation taken.
    function automatic ras_op_e ras_decode(
        input logic update_valid,
        input logic link_valid,
        input logic ret_valid
    );
        ras_op_e op;
        if (update_valid) begin
            op = RAS_OP_RESTORE;
        end else if (link_valid && ret_valid) begin
            op = RAS_OP_REPLACE;
        end else if (link_valid) begin
            op = RAS_OP_PUSH;
        end else if (ret_valid) begin
            op = RAS_OP_POP;
        end else begin
            op = RAS_OP_IDLE;
        end
        return op;
    endfunction

endpackage

// File: rtl/ras_restorable.sv
// Return address stack with checkpoint/restore for the fetch predictor.
// Calls push their link target, returns read the top entry and pop it.
// The pointer and occupancy are exported so predict metadata can carry them
// and the update path can reload both after a mispredict.
//
// Request semantics: link_valid, ret_valid and update_valid are single-cycle
// strobes with no back-pressure; every asserted strobe is consumed on the
// next rising CLK edge. update_valid wins over link/ret in the same cycle.
module ras_restorable #(
    parameter int RAS_ENTRIES       = ras_restorable_pkg::RAS_ENTRIES,
    parameter int RAS_TARGET_WIDTH  = ras_restorable_pkg::RAS_TARGET_WIDTH,
    parameter int RAS_OVERFLOW_MODE = ras_restorable_pkg::RAS_OVERFLOW_WRAP,
    localparam int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
    localparam int RAS_COUNT_WIDTH  = $clog2(RAS_ENTRIES + 1)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        link_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] link_target,
    input  logic                        ret_valid,
    output logic [RAS_TARGET_WIDTH-1:0] ret_target,
    output logic                        ret_target_valid,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
    output logic [RAS_COUNT_WIDTH-1:0]  ras_count,
    output logic                        overflow_event,
    input  logic                        update_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  update_ras_index,
    input  logic [RAS_COUNT_WIDTH-1:0]  update_ras_count
);

    import ras_restorable_pkg::*;

    localparam logic [RAS_COUNT_WIDTH-1:0] COUNT_FULL = RAS_COUNT_WIDTH'(RAS_ENTRIES);
    localparam logic [RAS_COUNT_WIDTH-1:0] COUNT_ONE  = RAS_COUNT_WIDTH'(1);
    localparam logic [RAS_INDEX_WIDTH-1:0] INDEX_ONE  = RAS_INDEX_WIDTH'(1);
    localparam bit   WRAP_ON_FULL = (RAS_OVERFLOW_MODE == RAS_OVERFLOW_WRAP);

    // Architectural state: entry array, top pointer, occupancy.
    logic [RAS_TARGET_WIDTH-1:0] entries [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]  ptr;
    logic [RAS_COUNT_WIDTH-1:0]  count;

    // Next-state and write-port signals.
    logic [RAS_INDEX_WIDTH-1:0]  ptr_next;
    logic [RAS_COUNT_WIDTH-1:0]  count_next;
    logic [RAS_INDEX_WIDTH-1:0]  ptr_inc;
    logic [RAS_INDEX_WIDTH-1:0]  ptr_dec;
    logic [RAS_COUNT_WIDTH-1:0]  restore_count;
    logic                        wr_en;
    logic [RAS_INDEX_WIDTH-1:0]  wr_index;
    logic                        full;
    logic                        empty;
    ras_op_e                     op;

    assign op    = ras_decode(update_valid, link_valid, ret_valid);
    assign full  = (count == COUNT_FULL);
    assign empty = (count == '0);

    // Modulo-N pointer movement falls out of the index width truncation.
    assign ptr_inc = ptr + INDEX_ONE;
    assign ptr_dec = ptr - INDEX_ONE;

    // A checkpoint can carry any count encoding; never exceed the depth.
    assign restore_count = (update_ras_count > COUNT_FULL) ? COUNT_FULL : update_ras_count;

    // Work out the pointer/count update and the single entry write per cycle.
    always_comb begin
        ptr_next   = ptr;
        count_next = count;
        wr_en      = 1'b0;
        wr_index   = ptr;
        unique case (op)
            RAS_OP_RESTORE: begin
                // Entries are left as they are; only the view is rewound.
                ptr_next   = update_ras_index;
                count_next = restore_count;
            end
            RAS_OP_REPLACE: begin
                // Call and return together: overwrite the top in place.
                wr_en    = 1'b1;
                wr_index = ptr;
                if (empty) begin
                    count_next = COUNT_ONE;
                end
            end
            RAS_OP_PUSH: begin
                if (!full) begin
                    ptr_next   = ptr_inc;
                    count_next = count + COUNT_ONE;
                    wr_en      = 1'b1;
                    wr_index   = ptr_inc;
                end else if (WRAP_ON_FULL) begin
                    // Advancing onto the oldest slot overwrites it; depth stays N.
                    ptr_next = ptr_inc;
                    wr_en    = 1'b1;
                    wr_index = ptr_inc;
                end
            end
            RAS_OP_POP: begin
                // An empty stack ignores the pop and keeps its pointer.
                if (!empty) begin
                    ptr_next   = ptr_dec;
                    count_next = count - COUNT_ONE;
                end
            end
            default: begin
            end
        endcase
    end

    // Top pointer and occupancy registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr   <= '0;
            count <= '0;
        end else begin
            ptr   <= ptr_next;
            count <= count_next;
        end
    end

    // Entry register file, one write port.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else if (wr_en) begin
            entries[wr_index] <= link_target;
        end
    end

    // State-derived outputs; overflow is the only one that looks at inputs.
    assign ret_target       = entries[ptr];
    assign ret_target_valid = !empty;
    assign ras_index        = ptr;
    assign ras_count        = count;
    assign overflow_event   = (op == RAS_OP_PUSH) && full;

endmodule

// File: tb/tb_ras_restorable.sv
// Bench for ras_restorable: one wrap-mode and one drop-mode instance share
// the same stimulus. Directed table, hand sequences for overflow, restore
// and reset, then random traffic against a circular-buffer reference model.
module tb_ras_restorable;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int CW = 4;
  localparam int TW = 31;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic          link_valid;
  logic [TW-1:0] link_target;
  logic          ret_valid;
  logic          update_valid;
  logic [IW-1:0] update_ras_index;
  logic [CW-1:0] update_ras_count;

  // Index 0 = wrap mode, index 1 = drop mode
  logic [TW-1:0] ret_target_w       [2];
  logic          ret_target_valid_w [2];
  logic [IW-1:0] ras_index_w        [2];
  logic [CW-1:0] ras_count_w        [2];
  logic          overflow_event_w   [2];

  ras_restorable #(.RAS_ENTRIES(N), .RAS_TARGET_WIDTH(TW), .RAS_OVERFLOW_MODE(0)) dut_wrap (
    .CLK(CLK), .RST(RST),
    .link_valid(link_valid), .link_target(link_target), .ret_valid(ret_valid),
    .ret_target(ret_target_w[0]), .ret_target_valid(ret_target_valid_w[0]),
    .ras_index(ras_index_w[0]), .ras_count(ras_count_w[0]),
    .overflow_event(overflow_event_w[0]),
    .update_valid(update_valid), .update_ras_index(update_ras_index),
    .update_ras_count(update_ras_count)
  );

  ras_restorable #(.RAS_ENTRIES(N), .RAS_TARGET_WIDTH(TW), .RAS_OVERFLOW_MODE(1)) dut_drop (
    .CLK(CLK), .RST(RST),
    .link_valid(link_valid), .link_target(link_target), .ret_valid(ret_valid),
    .ret_target(ret_target_w[1]), .ret_target_valid(ret_target_valid_w[1]),
    .ras_index(ras_index_w[1]), .ras_count(ras_count_w[1]),
    .overflow_event(overflow_event_w[1]),
    .update_valid(update_valid), .update_ras_index(update_ras_index),
    .update_ras_count(update_ras_count)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [TW-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Circular buffer of N slots per mode, top index and occupancy as integers.
  logic [TW-1:0] mdl_mem [2][N];
  int            mdl_ptr [2];
  int            mdl_cnt [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mdl_ptr[m] = 0;
      mdl_cnt[m] = 0;
      for (int i = 0; i < N; i++) mdl_mem[m][i] = '0;
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      if (update_valid) begin
        mdl_ptr[m] = int'(update_ras_index);
        mdl_cnt[m] = (int'(update_ras_count) > N) ? N : int'(update_ras_count);
      end else if (link_valid && ret_valid) begin
        mdl_mem[m][mdl_ptr[m]] = link_target;
        if (mdl_cnt[m] == 0) mdl_cnt[m] = 1;
      end else if (link_valid) begin
        if (mdl_cnt[m] < N || m == 0) begin
          mdl_ptr[m] = (mdl_ptr[m] + 1) % N;
          mdl_mem[m][mdl_ptr[m]] = link_target;
          if (mdl_cnt[m] < N) mdl_cnt[m]++;
        end
      end else if (ret_valid && mdl_cnt[m] > 0) begin
        mdl_ptr[m] = (mdl_ptr[m] + N - 1) % N;
        mdl_cnt[m]--;
      end
    end
  endtask

  task automatic check_model(input string tag);
    for (int m = 0; m < 2; m++) begin
      logic exp_ovf;
      exp_ovf = !update_valid && link_valid && !ret_valid && (mdl_cnt[m] == N);
      chk($sformatf("%s_m%0d_target", tag, m), 32'(ret_target_w[m]), 32'(mdl_mem[m][mdl_ptr[m]]));
      chk($sformatf("%s_m%0d_valid", tag, m), 32'(ret_target_valid_w[m]), 32'(mdl_cnt[m] != 0));
      chk($sformatf("%s_m%0d_index", tag, m), 32'(ras_index_w[m]), 32'(mdl_ptr[m]));
      chk($sformatf("%s_m%0d_count", tag, m), 32'(ras_count_w[m]), 32'(mdl_cnt[m]));
      chk($sformatf("%s_m%0d_ovf", tag, m), 32'(overflow_event_w[m]), 32'(exp_ovf));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic lk, input logic [TW-1:0] tgt, input logic rt,
                       input logic up, input logic [IW-1:0] ui, input logic [CW-1:0] uc);
    link_valid       = lk;
    link_target      = tgt;
    ret_valid        = rt;
    update_valid     = up;
    update_ras_index = ui;
    update_ras_count = uc;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    link_valid = 1'b0; link_target = '0; ret_valid = 1'b0;
    update_valid = 1'b0; update_ras_index = '0; update_ras_count = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  function automatic logic [TW-1:0] tk(input int k);
    return TW'(k * 'h100);
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic          lk;
    logic [TW-1:0] tgt;
    logic          rt;
    logic [TW-1:0] e_tgt;
    logic          e_val;
    int            e_idx;
    int            e_cnt;
    logic          e_ovf;
  } vec_t;

  vec_t vecs [11];

  initial begin
    // Expected outputs are those seen before the edge that consumes the row.
    vecs[0]  = '{1'b1, 31'h1000, 1'b0, 31'h0,    1'b0, 0, 0, 1'b0}; // reset view, push A
    vecs[1]  = '{1'b1, 31'h2000, 1'b0, 31'h1000, 1'b1, 1, 1, 1'b0}; // push B
    vecs[2]  = '{1'b0, 31'h0,    1'b1, 31'h2000, 1'b1, 2, 2, 1'b0}; // pop shows old top
    vecs[3]  = '{1'b0, 31'h0,    1'b0, 31'h1000, 1'b1, 1, 1, 1'b0}; // idle after pop
    vecs[4]  = '{1'b1, 31'h3000, 1'b1, 31'h1000, 1'b1, 1, 1, 1'b0}; // replace top
    vecs[5]  = '{1'b0, 31'h0,    1'b0, 31'h3000, 1'b1, 1, 1, 1'b0}; // replaced value
    vecs[6]  = '{1'b0, 31'h0,    1'b1, 31'h3000, 1'b1, 1, 1, 1'b0}; // pop to empty
    vecs[7]  = '{1'b0, 31'h0,    1'b1, 31'h0,    1'b0, 0, 0, 1'b0}; // pop while empty
    vecs[8]  = '{1'b1, 31'h4444, 1'b1, 31'h0,    1'b0, 0, 0, 1'b0}; // replace while empty
    vecs[9]  = '{1'b0, 31'h0,    1'b0, 31'h4444, 1'b1, 0, 1, 1'b0}; // count became 1
    vecs[10] = '{1'b0, 31'h0,    1'b1, 31'h4444, 1'b1, 0, 1, 1'b0}; // pop it

    do_reset();

    for (int v = 0; v < 11; v++) begin
      drive(vecs[v].lk, vecs[v].tgt, vecs[v].rt, 1'b0, '0, '0);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("vec%0d_m%0d_target", v, m), 32'(ret_target_w[m]), 32'(vecs[v].e_tgt));
        chk($sformatf("vec%0d_m%0d_valid", v, m), 32'(ret_target_valid_w[m]), 32'(vecs[v].e_val));
        chk($sformatf("vec%0d_m%0d_index", v, m), 32'(ras_index_w[m]), 32'(vecs[v].e_idx));
        chk($sformatf("vec%0d_m%0d_count", v, m), 32'(ras_count_w[m]), 32'(vecs[v].e_cnt));
        chk($sformatf("vec%0d_m%0d_ovf", v, m), 32'(overflow_event_w[m]), 32'(vecs[v].e_ovf));
      end
      tick();
    end

    // ---------------- overflow: push 9 into depth 8 ----------------
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, tk(k), 1'b0, 1'b0, '0, '0);
      chk($sformatf("ovf_push%0d_wrap", k), 32'(overflow_event_w[0]), 32'(k == 9));
      chk($sformatf("ovf_push%0d_drop", k), 32'(overflow_event_w[1]), 32'(k == 9));
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("ovf_wrap_count", 32'(ras_count_w[0]), 32'd8);
    chk("ovf_wrap_top", 32'(ret_target_w[0]), 32'(tk(9)));
    chk("ovf_wrap_index", 32'(ras_index_w[0]), 32'd1);
    chk("ovf_drop_count", 32'(ras_count_w[1]), 32'd8);
    chk("ovf_drop_top", 32'(ret_target_w[1]), 32'(tk(8)));
    chk("ovf_drop_index", 32'(ras_index_w[1]), 32'd0);

    for (int k = 9; k >= 2; k--) exp_q.push_back(tk(k));
    for (int p = 0; p < 8; p++) begin
      logic [TW-1:0] e;
      drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
      e = exp_q.pop_front();
      chk($sformatf("ovf_pop%0d_wrap", p), 32'(ret_target_w[0]), 32'(e));
      chk($sformatf("ovf_pop%0d_drop", p), 32'(ret_target_w[1]), 32'(tk(8 - p)));
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("ovf_empty_wrap_valid", 32'(ret_target_valid_w[0]), 32'd0);
    chk("ovf_empty_drop_valid", 32'(ret_target_valid_w[1]), 32'd0);
    chk("ovf_empty_wrap_count", 32'(ras_count_w[0]), 32'd0);

    // ---------------- restore from checkpoint ----------------
    do_reset();
    drive(1'b1, 31'h111, 1'b0, 1'b0, '0, '0); tick();
    drive(1'b1, 31'h222, 1'b0, 1'b0, '0, '0); tick();
    drive(1'b1, 31'h333, 1'b0, 1'b0, '0, '0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("rst_ckpt_index", 32'(ras_index_w[0]), 32'd3);
    chk("rst_ckpt_count", 32'(ras_count_w[0]), 32'd3);
    drive(1'b1, 31'h444, 1'b0, 1'b0, '0, '0); tick();
    drive(1'b1, 31'h555, 1'b0, 1'b0, '0, '0); tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0); tick();
    drive(1'b1, 31'h7777, 1'b0, 1'b1, 3'd3, 4'd3);
    chk("restore_ovf", 32'(overflow_event_w[0]), 32'd0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("restore_index", 32'(ras_index_w[0]), 32'd3);
    chk("restore_count", 32'(ras_count_w[0]), 32'd3);
    chk("restore_top", 32'(ret_target_w[0]), 32'h333);
    // Oversized count saturates at the depth
    drive(1'b0, '0, 1'b0, 1'b1, 3'd5, 4'd15); tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("restore_clamp_count", 32'(ras_count_w[1]), 32'd8);
    chk("restore_clamp_index", 32'(ras_index_w[1]), 32'd5);
    // Restore while full with a push pending: no overflow, push ignored
    drive(1'b1, 31'h6666, 1'b0, 1'b1, 3'd2, 4'd8);
    chk("restore_full_ovf_wrap", 32'(overflow_event_w[0]), 32'd0);
    chk("restore_full_ovf_drop", 32'(overflow_event_w[1]), 32'd0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("restore_full_index", 32'(ras_index_w[0]), 32'd2);
    chk("restore_full_top", 32'(ret_target_w[0]), 32'h222);

    // ---------------- asynchronous reset mid-sequence ----------------
    drive(1'b1, 31'hABCD, 1'b0, 1'b0, '0, '0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #2 RST = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("arst_m%0d_target", m), 32'(ret_target_w[m]), 32'd0);
      chk($sformatf("arst_m%0d_valid", m), 32'(ret_target_valid_w[m]), 32'd0);
      chk($sformatf("arst_m%0d_index", m), 32'(ras_index_w[m]), 32'd0);
      chk($sformatf("arst_m%0d_count", m), 32'(ras_count_w[m]), 32'd0);
      chk($sformatf("arst_m%0d_ovf", m), 32'(overflow_event_w[m]), 32'd0);
    end
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    drive(1'b1, 31'hABC, 1'b0, 1'b0, '0, '0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("arst_first_push_count", 32'(ras_count_w[0]), 32'd1);
    chk("arst_first_push_top", 32'(ret_target_w[0]), 32'hABC);
    chk("arst_first_push_index", 32'(ras_index_w[0]), 32'd1);

    // ---------------- random traffic vs reference model ----------------
    do_reset();
    for (int c = 0; c < 800; c++) begin
      logic lk, rt, up;
      lk = ($urandom_range(0, 99) < 55);
      rt = ($urandom_range(0, 99) < 40);
      up = ($urandom_range(0, 15) == 0);
      drive(lk, TW'($urandom()), rt, up, IW'($urandom_range(0, N - 1)),
            CW'($urandom_range(0, 15)));
      check_model("rnd");
      tick();
    end

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
